// File: rtl/arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
// Counter width bounds the largest supported memory read latency (7).
package arbiter_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_WAIT = 1'b1} arb_state_e;
  typedef enum logic {SRC_IF = 1'b0, SRC_ME = 1'b1} arb_src_e;
  localparam int unsigned CNT_W = 3;
endpackage

// File: rtl/arb_latency_counter.sv
// Loadable down-counter that tracks the cycles left before read data returns.
// It saturates at zero, and zero_o flags the capture cycle.
module arb_latency_counter
  import arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/unified_memory_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data access.
// ME has priority, and the pipeline is stalled until every requester of the cycle is done.
module unified_memory_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_done,
  input  logic                  me_read,
  input  logic                  me_write,
  input  logic [ADDR_WIDTH-1:0] me_addr,
  input  logic [DATA_WIDTH-1:0] me_wdata,
  output logic [DATA_WIDTH-1:0] me_rdata,
  output logic                  me_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall
);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  arb_state_e            state_q, state_d;
  arb_src_e              src_q, src_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, me_rdata_q, me_rdata_d;
  logic                  if_done_q, if_done_d, me_done_q, me_done_d;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic                  cap_if, cap_me, wr_done;
  logic                  if_pend, me_pend;

  arb_latency_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (LAT),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign if_pend = if_req & ~if_done_q;
  assign me_pend = (me_read | me_write) & ~me_done_q;
  assign stall   = if_pend | me_pend;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    cap_if      = 1'b0;
    cap_me      = 1'b0;
    wr_done     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // A simultaneous read+write from ME is resolved as a write.
        if (me_pend) begin
          src_d       = SRC_ME;
          wr_d        = me_write;
          mem_addr_d  = me_addr;
          mem_wdata_d = me_wdata;
          mem_we_d    = me_write;
          mem_re_d    = ~me_write;
          cnt_load    = 1'b1;
          state_d     = ARB_WAIT;
        end else if (if_pend) begin
          src_d      = SRC_IF;
          wr_d       = 1'b0;
          mem_addr_d = if_addr;
          mem_re_d   = 1'b1;
          cnt_load   = 1'b1;
          state_d    = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (wr_q) begin
          wr_done = 1'b1;
          state_d = ARB_IDLE;
        end else if (cnt_zero) begin
          cap_if  = (src_q == SRC_IF);
          cap_me  = (src_q == SRC_ME);
          state_d = ARB_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // A completion landing in an unstalled cycle must still be seen, so set beats clear.
  assign if_done_d  = cap_if | (if_done_q & stall);
  assign me_done_d  = cap_me | wr_done | (me_done_q & stall);
  assign if_rdata_d = cap_if ? mem_rdata : if_rdata_q;
  assign me_rdata_d = cap_me ? mem_rdata : me_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      src_q       <= SRC_IF;
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rdata_q  <= '0;
      me_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      me_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      if_rdata_q  <= if_rdata_d;
      me_rdata_q  <= me_rdata_d;
      if_done_q   <= if_done_d;
      me_done_q   <= me_done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign if_rdata  = if_rdata_q;
  assign me_rdata  = me_rdata_q;
  assign if_done   = if_done_q;
  assign me_done   = me_done_q;
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for the arbiter: one instance at latency 1, one at latency 4,
// each backed by a small behavioural memory with the matching read latency.
module tb_unified_memory_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Latency-1 instance signals
  logic        if_req1, me_read1, me_write1;
  logic [31:0] if_addr1, me_addr1, me_wdata1;
  logic [31:0] if_rdata1, me_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_done1, me_done1, mem_re1, mem_we1, stall1;

  // Latency-4 instance signals
  logic        if_req4, me_read4, me_write4;
  logic [31:0] if_addr4, me_addr4, me_wdata4;
  logic [31:0] if_rdata4, me_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
  logic        if_done4, me_done4, mem_re4, mem_we4, stall4;

  unified_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_done(if_done1),
    .me_read(me_read1), .me_write(me_write1), .me_addr(me_addr1), .me_wdata(me_wdata1),
    .me_rdata(me_rdata1), .me_done(me_done1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_re(mem_re1), .mem_we(mem_we1),
    .mem_rdata(mem_rdata1), .stall(stall1)
  );

  unified_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset),
    .if_req(if_req4), .if_addr(if_addr4), .if_rdata(if_rdata4), .if_done(if_done4),
    .me_read(me_read4), .me_write(me_write4), .me_addr(me_addr4), .me_wdata(me_wdata4),
    .me_rdata(me_rdata4), .me_done(me_done4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_re(mem_re4), .mem_we(mem_we4),
    .mem_rdata(mem_rdata4), .stall(stall4)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h10:  rom = 32'h2010_0004;
      32'h14:  rom = 32'h8C08_0000;
      32'h100: rom = 32'hDEAD_BEEF;
      32'h20:  rom = 32'h0123_4567;
      32'h24:  rom = 32'h55AA_33CC;
      32'h28:  rom = 32'h7777_0028;
      default: rom = 32'h0;
    endcase
  endfunction

  // Memory for dut1: preloaded words plus a writable overlay, latency 1
  logic [31:0] wmem1 [0:255];
  logic [255:0] wv1;
  logic [31:0] pipe1;
  always @(posedge clk) begin
    if (reset) wv1 <= '0;
    else if (mem_we1) begin
      wmem1[mem_addr1[9:2]] <= mem_wdata1;
      wv1[mem_addr1[9:2]]   <= 1'b1;
    end
    if (mem_re1)
      pipe1 <= wv1[mem_addr1[9:2]] ? wmem1[mem_addr1[9:2]] : rom(mem_addr1);
    else
      pipe1 <= 32'hBAD0_BAD0;
  end
  assign mem_rdata1 = pipe1;

  // Memory for dut4: read-only, latency 4 (unaffected by arbiter reset)
  logic [31:0] pipe4 [0:3];
  always @(posedge clk) begin
    pipe4[0] <= mem_re4 ? rom(mem_addr4) : 32'hBAD0_BAD0;
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign mem_rdata4 = pipe4[3];

  int re1_cnt = 0, we1_cnt = 0, re4_cnt = 0;
  always @(posedge clk) begin
    if (mem_re1) re1_cnt <= re1_cnt + 1;
    if (mem_we1) we1_cnt <= we1_cnt + 1;
    if (mem_re4) re4_cnt <= re4_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; checks then happen a few ns later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int re_base, we_base;

  initial begin
    reset = 1'b1;
    if_req1 = 0; me_read1 = 0; me_write1 = 0; if_addr1 = 0; me_addr1 = 0; me_wdata1 = 0;
    if_req4 = 0; me_read4 = 0; me_write4 = 0; if_addr4 = 0; me_addr4 = 0; me_wdata4 = 0;
    nxt(); nxt(); #3;
    chk("rst_if_done", {31'd0, if_done1}, 0);
    chk("rst_me_done", {31'd0, me_done1}, 0);
    chk("rst_mem_re", {31'd0, mem_re1}, 0);
    chk("rst_mem_we", {31'd0, mem_we1}, 0);
    chk("rst_mem_addr", mem_addr1, 0);
    chk("rst_if_rdata", if_rdata1, 0);
    chk("rst_me_rdata", me_rdata1, 0);
    chk("rst_stall", {31'd0, stall1}, 0);
    nxt(); reset = 1'b0;

    // IF only, latency 1
    nxt(); if_req1 = 1; if_addr1 = 32'h10; #3;
    chk("t1_c0_stall", {31'd0, stall1}, 1);
    chk("t1_c0_re", {31'd0, mem_re1}, 0);
    nxt(); #3;
    chk("t1_c1_re", {31'd0, mem_re1}, 1);
    chk("t1_c1_addr", mem_addr1, 32'h10);
    chk("t1_c1_stall", {31'd0, stall1}, 1);
    nxt(); #3;
    chk("t1_c2_re", {31'd0, mem_re1}, 0);
    chk("t1_c2_done", {31'd0, if_done1}, 0);
    chk("t1_c2_stall", {31'd0, stall1}, 1);
    nxt(); #3;
    chk("t1_c3_done", {31'd0, if_done1}, 1);
    chk("t1_c3_rdata", if_rdata1, 32'h2010_0004);
    chk("t1_c3_stall", {31'd0, stall1}, 0);
    nxt(); if_req1 = 0; #3;
    chk("t1_c4_clear", {31'd0, if_done1}, 0);

    // IF and ME read together: ME first, then IF
    nxt(); if_req1 = 1; if_addr1 = 32'h14; me_read1 = 1; me_addr1 = 32'h100; #3;
    chk("t2_c0_stall", {31'd0, stall1}, 1);
    nxt(); #3;
    chk("t2_c1_re", {31'd0, mem_re1}, 1);
    chk("t2_c1_addr", mem_addr1, 32'h100);
    nxt(); #3;
    chk("t2_c2_re", {31'd0, mem_re1}, 0);
    nxt(); #3;
    chk("t2_c3_me_done", {31'd0, me_done1}, 1);
    chk("t2_c3_me_rdata", me_rdata1, 32'hDEAD_BEEF);
    chk("t2_c3_stall", {31'd0, stall1}, 1);
    chk("t2_c3_re", {31'd0, mem_re1}, 0);
    nxt(); #3;
    chk("t2_c4_re", {31'd0, mem_re1}, 1);
    chk("t2_c4_addr", mem_addr1, 32'h14);
    nxt(); #3;
    chk("t2_c5_stall", {31'd0, stall1}, 1);
    nxt(); #3;
    chk("t2_c6_stall", {31'd0, stall1}, 0);
    chk("t2_c6_if_done", {31'd0, if_done1}, 1);
    chk("t2_c6_if_rdata", if_rdata1, 32'h8C08_0000);
    chk("t2_c6_me_rdata", me_rdata1, 32'hDEAD_BEEF);
    nxt(); if_req1 = 0; me_read1 = 0; #3;
    chk("t2_c7_if_clr", {31'd0, if_done1}, 0);
    chk("t2_c7_me_clr", {31'd0, me_done1}, 0);

    // Store then load back
    nxt(); me_write1 = 1; me_addr1 = 32'h104; me_wdata1 = 32'h1234_5678; #3;
    nxt(); #3;
    chk("t3_c1_we", {31'd0, mem_we1}, 1);
    chk("t3_c1_re", {31'd0, mem_re1}, 0);
    chk("t3_c1_addr", mem_addr1, 32'h104);
    chk("t3_c1_wdata", mem_wdata1, 32'h1234_5678);
    nxt(); #3;
    chk("t3_c2_we", {31'd0, mem_we1}, 0);
    chk("t3_c2_done", {31'd0, me_done1}, 1);
    chk("t3_c2_stall", {31'd0, stall1}, 0);
    nxt(); me_write1 = 0; me_read1 = 1; #3;
    chk("t3_c3_done_clr", {31'd0, me_done1}, 0);
    chk("t3_c3_stall", {31'd0, stall1}, 1);
    nxt(); #3;
    chk("t3_c4_re", {31'd0, mem_re1}, 1);
    nxt(); nxt(); #3;
    chk("t3_c6_done", {31'd0, me_done1}, 1);
    chk("t3_c6_rdata", me_rdata1, 32'h1234_5678);
    nxt(); me_read1 = 0;

    // Read and write together: treated as a write
    re_base = re1_cnt; we_base = we1_cnt;
    nxt(); me_read1 = 1; me_write1 = 1; me_addr1 = 32'h108; me_wdata1 = 32'hCAFE_0001; #3;
    nxt(); #3;
    chk("t4_c1_we", {31'd0, mem_we1}, 1);
    chk("t4_c1_re", {31'd0, mem_re1}, 0);
    nxt(); #3;
    chk("t4_c2_done", {31'd0, me_done1}, 1);
    nxt(); me_read1 = 0; me_write1 = 0; #3;
    chk("t4_we_pulses", we1_cnt - we_base, 1);
    chk("t4_re_pulses", re1_cnt - re_base, 0);

    // Latency 4, IF read
    re_base = re4_cnt;
    nxt(); if_req4 = 1; if_addr4 = 32'h20; #3;
    nxt(); #3;
    chk("t5_c1_re", {31'd0, mem_re4}, 1);
    nxt(); nxt(); nxt(); nxt(); #3;
    chk("t5_c5_done", {31'd0, if_done4}, 0);
    chk("t5_c5_stall", {31'd0, stall4}, 1);
    nxt(); #3;
    chk("t5_c6_done", {31'd0, if_done4}, 1);
    chk("t5_c6_rdata", if_rdata4, 32'h0123_4567);
    chk("t5_c6_stall", {31'd0, stall4}, 0);
    nxt(); if_req4 = 0; #3;
    chk("t5_re_pulses", re4_cnt - re_base, 1);
    chk("t5_c7_clr", {31'd0, if_done4}, 0);

    // Reset two cycles into a latency-4 read
    nxt(); if_req4 = 1; if_addr4 = 32'h24; #3;
    nxt(); #3;
    chk("t6_c1_re", {31'd0, mem_re4}, 1);
    nxt(); reset = 1; if_req4 = 0;
    nxt(); reset = 0; #3;
    chk("t6_rst_re", {31'd0, mem_re4}, 0);
    chk("t6_rst_we", {31'd0, mem_we4}, 0);
    chk("t6_rst_addr", mem_addr4, 0);
    chk("t6_rst_wdata", mem_wdata4, 0);
    chk("t6_rst_if_rdata", if_rdata4, 0);
    chk("t6_rst_me_rdata", me_rdata4, 0);
    chk("t6_rst_if_done", {31'd0, if_done4}, 0);
    chk("t6_rst_me_done", {31'd0, me_done4}, 0);
    nxt(); nxt(); nxt(); nxt(); #3;
    chk("t6_late_rdata", if_rdata4, 0);
    chk("t6_late_done", {31'd0, if_done4}, 0);
    re_base = re4_cnt;
    nxt(); if_req4 = 1; if_addr4 = 32'h28; #3;
    nxt(); nxt(); nxt(); nxt(); nxt(); #3;
    chk("t6_fresh_c5_done", {31'd0, if_done4}, 0);
    nxt(); #3;
    chk("t6_fresh_done", {31'd0, if_done4}, 1);
    chk("t6_fresh_rdata", if_rdata4, 32'h7777_0028);
    chk("t6_fresh_pulses", re4_cnt - re_base, 1);
    nxt(); if_req4 = 0;
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
